// File: rtl/sprite_layer_renderer.sv
// Scaled, animated, palette-indexed sprite overlay on a background pixel stream.
// Three-stage pipeline around an external synchronous ROM and combinational palette.
module sprite_layer_renderer #(
    parameter int unsigned SPRITE_W    = 50,
    parameter int unsigned SPRITE_H    = 50,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned FRAMES      = 4,
    parameter int unsigned ANIM_DIV    = 8,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TRANSP_IDX  = 0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              sprite_en,
    input  logic              flip_h,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit
);

    localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [10:0]        SPAN_X     = 11'(SPRITE_W << SCALE_SHIFT);
    localparam logic [10:0]        SPAN_Y     = 11'(SPRITE_H << SCALE_SHIFT);
    localparam logic [10:0]        COL_MAX    = 11'(SPRITE_W - 1);
    localparam logic [ADDR_W-1:0]  FRAME_SZ   = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0]  ROW_SZ     = ADDR_W'(SPRITE_W);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
    localparam logic [IDX_W-1:0]   TRANSP     = IDX_W'(TRANSP_IDX);

    // Shadow copies of the sprite request, frozen for the whole video frame
    logic [9:0]         sx_q, sx_d;
    logic [9:0]         sy_q, sy_d;
    logic               en_q, en_d;
    logic               flip_q, flip_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               s1_inside_q, s1_inside_d;
    logic               s1_blank_q;
    logic [11:0]        s1_bg_q;
    logic               s2_inside_q;
    logic               s2_blank_q;
    logic [11:0]        s2_bg_q;
    logic [11:0]        rgb_q, rgb_d;
    logic               hit_q, hit_d;

    logic [10:0] x_ext, y_ext, sx_ext, sy_ext;
    logic [10:0] dx, dy, col_raw, col, row;
    logic        in_x, in_y;

    always_comb begin
        sx_d    = sx_q;
        sy_d    = sy_q;
        en_d    = en_q;
        flip_d  = flip_q;
        div_d   = div_q;
        frame_d = frame_q;
        if (frame_start) begin
            sx_d   = sprite_x;
            sy_d   = sprite_y;
            en_d   = sprite_en;
            flip_d = flip_h;
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping
    always_comb begin
        x_ext   = {1'b0, DrawX};
        y_ext   = {1'b0, DrawY};
        sx_ext  = {1'b0, sx_q};
        sy_ext  = {1'b0, sy_q};
        dx      = x_ext - sx_ext;
        dy      = y_ext - sy_ext;
        in_x    = (x_ext >= sx_ext) && (x_ext < sx_ext + SPAN_X);
        in_y    = (y_ext >= sy_ext) && (y_ext < sy_ext + SPAN_Y);
        col_raw = dx >> SCALE_SHIFT;
        row     = dy >> SCALE_SHIFT;
        col     = flip_q ? (COL_MAX - col_raw) : col_raw;
        s1_inside_d = in_x && in_y && en_q;
        addr_d      = '0;
        if (s1_inside_d) begin
            addr_d = FRAME_SZ * ADDR_W'(frame_q) + ROW_SZ * ADDR_W'(row) + ADDR_W'(col);
        end
    end

    always_comb begin
        rgb_d = s2_bg_q;
        hit_d = 1'b0;
        if (!s2_blank_q) begin
            rgb_d = '0;
        end else if (s2_inside_q && (rom_q != TRANSP)) begin
            rgb_d = {pal_red, pal_green, pal_blue};
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q        <= '0;
            sy_q        <= '0;
            en_q        <= 1'b0;
            flip_q      <= 1'b0;
            div_q       <= '0;
            frame_q     <= '0;
            addr_q      <= '0;
            s1_inside_q <= 1'b0;
            s1_blank_q  <= 1'b0;
            s1_bg_q     <= '0;
            s2_inside_q <= 1'b0;
            s2_blank_q  <= 1'b0;
            s2_bg_q     <= '0;
            rgb_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            en_q        <= en_d;
            flip_q      <= flip_d;
            div_q       <= div_d;
            frame_q     <= frame_d;
            addr_q      <= addr_d;
            s1_inside_q <= s1_inside_d;
            s1_blank_q  <= blank;
            s1_bg_q     <= {bg_red, bg_green, bg_blue};
            s2_inside_q <= s1_inside_q;
            s2_blank_q  <= s1_blank_q;
            s2_bg_q     <= s1_bg_q;
            rgb_q       <= rgb_d;
            hit_q       <= hit_d;
        end
    end

    assign rom_addr   = addr_q;
    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign sprite_hit = hit_q;

endmodule
